// File: rtl/masked_xor_scheduler_pkg.sv
// masked_sched_pkg: shared state encoding and LFSR constants for the masked XOR scheduler
package masked_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP,
        GAP
    } state_t;

    localparam logic [31:0] LFSR_MASK       = 32'h8020_0003;
    localparam logic [31:0] LFSR_ZERO_GUARD = 32'h0000_0001;

    // One right-shifting Galois step: the feedback mask is applied when the outgoing bit is set.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/masked_lfsr.sv
// masked_lfsr: 32-bit Galois LFSR that supplies per-operation randomness, with a seed load that never enters the all-zero lockup state
module masked_lfsr
    import masked_sched_pkg::*;
#(
    parameter logic [31:0] SEED_INIT = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] state_q, state_d;

    // Load wins over stepping; a zero seed is replaced so the register can never lock up.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == 32'h0) ? LFSR_ZERO_GUARD : seed;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register, returning to the seed constant on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/xor_gate_masked.sv
// xor_gate_masked: one-bit two-share XOR that re-masks both output shares with the same fresh bits
module xor_gate_masked (
    input  logic A0,
    input  logic A1,
    input  logic B0,
    input  logic B1,
    input  logic r0,
    input  logic r1,
    input  logic r2,
    output logic Y0,
    output logic Y1
);

    // Each share only ever combines with its own operand shares and randomness, so the secret is never formed here.
    assign Y0 = ((A0 ^ r0) ^ (B0 ^ r1)) ^ r2;
    assign Y1 = ((A1 ^ r0) ^ (B1 ^ r1)) ^ r2;

endmodule

// File: rtl/masked_xor_scheduler.sv
// masked_xor_scheduler: round-robin sharing of one W-bit masked XOR datapath with fresh randomness and an idle gap between operations
module masked_xor_scheduler
    import masked_sched_pkg::*;
#(
    parameter int          W         = 4,
    parameter int          NUM_REQ   = 2,
    parameter int          ID_W      = 2,
    parameter logic [31:0] SEED_INIT = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a0,
    input  logic [NUM_REQ*W-1:0] req_a1,
    input  logic [NUM_REQ*W-1:0] req_b0,
    input  logic [NUM_REQ*W-1:0] req_b1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_y0,
    output logic [W-1:0]         rsp_y1,
    input  logic [3:0]           gap_cycles,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    output logic                 busy
);

    logic [1:0]      rst_sync_q, rst_sync_d;
    logic            rst_int_n;
    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [3:0]      gap_q, gap_d;
    logic [W-1:0]    a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic [W-1:0]    y0_q, y0_d, y1_q, y1_d;
    logic [W-1:0]    y0, y1;
    logic [W-1:0]    sel_a0, sel_a1, sel_b0, sel_b1;
    logic [ID_W-1:0] grant, hi_idx, lo_idx;
    logic            hi_any, lo_any;
    logic [31:0]     lfsr_state;
    logic [3*W-1:0]  rnd;
    logic            unused_lfsr;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    // Reset synchronizer: assertion reaches every flop at once, release is aligned to the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    masked_lfsr #(
        .SEED_INIT(SEED_INIT)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_int_n),
        .step (1'b1),
        .load (seed_load),
        .seed (seed),
        .state(lfsr_state)
    );

    assign rnd         = lfsr_state[3*W-1:0];
    assign unused_lfsr = ^lfsr_state[31:3*W];

    for (genvar k = 0; k < W; k++) begin : g_bit
        xor_gate_masked u_gate (
            .A0(a0_q[k]),
            .A1(a1_q[k]),
            .B0(b0_q[k]),
            .B1(b1_q[k]),
            .r0(rnd[3*k]),
            .r1(rnd[3*k+1]),
            .r2(rnd[3*k+2]),
            .Y0(y0[k]),
            .Y1(y1[k])
        );
    end

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index overall; then route its operands.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_any = 1'b1;
                lo_idx = ID_W'(j);
                if (ID_W'(j) >= rr_ptr_q) begin
                    hi_any = 1'b1;
                    hi_idx = ID_W'(j);
                end
            end
        end
        grant     = hi_any ? hi_idx : lo_idx;
        sel_a0    = '0;
        sel_a1    = '0;
        sel_b0    = '0;
        sel_b1    = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant) begin
                sel_a0       = req_a0[i*W +: W];
                sel_a1       = req_a1[i*W +: W];
                sel_b0       = req_b0[i*W +: W];
                sel_b1       = req_b1[i*W +: W];
                req_ready[i] = (state_q == IDLE) && lo_any;
            end
        end
    end

    // Operation sequencing: accept in IDLE, evaluate for one cycle, hold the response, then sit out the gap.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        gap_d    = gap_q;
        a0_d     = a0_q;
        a1_d     = a1_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        case (state_q)
            IDLE: begin
                if (lo_any) begin
                    a0_d     = sel_a0;
                    a1_d     = sel_a1;
                    b0_d     = sel_b0;
                    b1_d     = sel_b1;
                    id_d     = grant;
                    gap_d    = gap_cycles;
                    rr_ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                y0_d     = y0;
                y1_d     = y1;
                rsp_id_d = id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = (gap_q != 4'd0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_d   = gap_q - 4'd1;
                state_d = (gap_q == 4'd1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler registers; a reset drops any in-flight operation and its response.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            rsp_id_q <= '0;
            gap_q    <= '0;
            a0_q     <= '0;
            a1_q     <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            gap_q    <= gap_d;
            a0_q     <= a0_d;
            a1_q     <= a1_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_y0    = y0_q;
    assign rsp_y1    = y1_q;

endmodule

// File: tb/tb_masked_xor_scheduler.sv
// tb_masked_xor_scheduler: scoreboard bench for the round-robin masked XOR scheduler
module tb_masked_xor_scheduler;

    localparam int          W       = 4;
    localparam int          NUM_REQ = 2;
    localparam int          ID_W    = 2;
    localparam logic [31:0] SEED    = 32'hACE1_0001;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    x;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a0, req_a1, req_b0, req_b1;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_y0, rsp_y1;
    logic [3:0]           gap_cycles;
    logic                 seed_load;
    logic [31:0]          seed;
    logic                 busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

    logic [31:0]    m_lfsr;
    logic [1:0]     m_live;
    int             m_rr;
    bit             eval_pend;
    bit             have_prev;
    logic [3*W-1:0] prev_rnd, prev_m;

    masked_xor_scheduler #(
        .W(W), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .SEED_INIT(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y0(rsp_y0), .rsp_y1(rsp_y1),
        .gap_cycles(gap_cycles), .seed_load(seed_load), .seed(seed), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] gstep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference LFSR: held at the seed while reset is asserted and for the two synchronizer cycles after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_live <= 2'b00;
        end else begin
            m_live <= {m_live[0], 1'b1};
            if (m_live[1]) m_lfsr <= seed_load ? ((seed == 32'h0) ? 32'h1 : seed) : gstep(m_lfsr);
        end
    end

    // Scoreboard monitor: grant order and expected results pushed on accept, randomness checked in EVAL, results popped on response.
    always @(negedge clk) begin
        int eg;
        int j;
        logic [NUM_REQ-1:0] want_rdy;
        exp_t e;
        if (!rst_n) begin
            eval_pend = 1'b0;
            m_rr = 0;
        end else begin
            if (eval_pend) begin
                n_checks++;
                if (dut.rnd !== m_lfsr[3*W-1:0]) $display("FAIL eval_rnd: got %h want %h", dut.rnd, m_lfsr[3*W-1:0]);
                else n_pass++;
                if (have_prev) begin
                    n_checks++;
                    if (dut.rnd === prev_rnd && m_lfsr[3*W-1:0] !== prev_m)
                        $display("FAIL rnd_fresh: repeated %h, model moved %h -> %h", dut.rnd, prev_m, m_lfsr[3*W-1:0]);
                    else n_pass++;
                end
                prev_rnd  = dut.rnd;
                prev_m    = m_lfsr[3*W-1:0];
                have_prev = 1'b1;
            end
            eval_pend = 1'b0;
            if (|(req_valid & req_ready)) begin
                eg = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (m_rr + k) % NUM_REQ;
                    if (eg < 0 && req_valid[j]) eg = j;
                end
                want_rdy = '0;
                want_rdy[eg] = 1'b1;
                n_checks++;
                if (req_ready !== want_rdy) $display("FAIL grant: req_ready %b want %b", req_ready, want_rdy);
                else n_pass++;
                e.id = ID_W'(eg);
                e.x  = (req_a0[eg*W +: W] ^ req_a1[eg*W +: W]) ^ (req_b0[eg*W +: W] ^ req_b1[eg*W +: W]);
                q.push_back(e);
                m_rr = (eg + 1) % NUM_REQ;
                eval_pend = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL sb_empty: response id %0d with nothing outstanding", rsp_id);
                end else begin
                    e = q.pop_front();
                    if (rsp_id !== e.id || (rsp_y0 ^ rsp_y1) !== e.x)
                        $display("FAIL sb_rsp: id %0d unmasked %h want id %0d unmasked %h", rsp_id, rsp_y0 ^ rsp_y1, e.id, e.x);
                    else n_pass++;
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [W-1:0] a0, input logic [W-1:0] a1,
                           input logic [W-1:0] b0, input logic [W-1:0] b1);
        req_a0[i*W +: W] = a0;
        req_a1[i*W +: W] = a1;
        req_b0[i*W +: W] = b0;
        req_b1[i*W +: W] = b1;
    endtask

    task automatic wait_accept(input int i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== '0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== '0) $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); else n_pass++;
        n_checks++; if (rsp_y0 !== '0) $display("FAIL rst_rsp_y0: got %h want 0", rsp_y0); else n_pass++;
        n_checks++; if (rsp_y1 !== '0) $display("FAIL rst_rsp_y1: got %h want 0", rsp_y1); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (dut.u_lfsr.state_q !== SEED) $display("FAIL rst_lfsr: got %h want %h", dut.u_lfsr.state_q, SEED); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit ok;
        int bcnt;
        set_ops(0, 4'hA, 4'h3, 4'h5, 4'hC);
        gap_cycles = 4'd0;
        rsp_ready  = 1'b1;
        req_valid  = 2'b01;
        wait_accept(0, ok);
        n_checks++; if (!ok) $display("FAIL single_accept: no handshake within bound"); else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        bcnt = 0;
        @(negedge clk);
        bcnt += int'(busy);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_lat1: rsp_valid %b want 0", rsp_valid); else n_pass++;
        @(negedge clk);
        bcnt += int'(busy);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_lat2: rsp_valid %b want 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d want 0", rsp_id); else n_pass++;
        n_checks++; if ((rsp_y0 ^ rsp_y1) !== 4'h0) $display("FAIL single_unmask: got %h want 0", rsp_y0 ^ rsp_y1); else n_pass++;
        repeat (2) begin
            @(negedge clk);
            bcnt += int'(busy);
        end
        n_checks++; if (bcnt != 2) $display("FAIL single_busy: busy for %0d cycles want 2", bcnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        int k;
        apply_reset();
        set_ops(0, 4'h1, 4'h2, 4'h4, 4'h8);
        set_ops(1, 4'h6, 4'h5, 4'h3, 4'h9);
        gap_cycles = 4'd0;
        rsp_ready  = 1'b1;
        req_valid  = 2'b11;
        k = 0;
        for (int n = 0; n < 60 && k < 4; n++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (rsp_id !== ID_W'(k % 2)) $display("FAIL rr_order: op %0d id %0d want %0d", k, rsp_id, k % 2);
                else n_pass++;
                n_checks++;
                if ((rsp_y0 ^ rsp_y1) !== ((k % 2 == 1) ? 4'h9 : 4'hF))
                    $display("FAIL rr_unmask: op %0d got %h want %h", k, rsp_y0 ^ rsp_y1, (k % 2 == 1) ? 4'h9 : 4'hF);
                else n_pass++;
                k++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        n_checks++; if (k != 4) $display("FAIL rr_count: %0d responses want 4", k); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure_gap();
        bit ok;
        int gcnt;
        logic [W-1:0] h0, h1;
        logic [ID_W-1:0] hid;
        set_ops(1, 4'h7, 4'h1, 4'h2, 4'hB);
        gap_cycles = 4'd3;
        rsp_ready  = 1'b0;
        req_valid  = 2'b10;
        wait_accept(1, ok);
        n_checks++; if (!ok) $display("FAIL bp_accept: no handshake within bound"); else n_pass++;
        @(posedge clk);
        #1;
        req_valid  = 2'b00;
        gap_cycles = 4'd9;
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        h0  = rsp_y0;
        h1  = rsp_y1;
        hid = rsp_id;
        for (int p = 0; p < 5; p++) begin
            if (p > 0) @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_y0 !== h0 || rsp_y1 !== h1 || rsp_id !== hid || hid !== 2'd1)
                $display("FAIL bp_hold: cycle %0d valid %b y %h/%h id %0d want 1 %h/%h id 1", p, rsp_valid, rsp_y0, rsp_y1, rsp_id, h0, h1);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rsp_ready  = 1'b1;
        gap_cycles = 4'd0;
        set_ops(0, 4'h3, 4'hE, 4'h8, 4'h1);
        req_valid  = 2'b01;
        @(negedge clk);
        gcnt = 0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (busy) begin
                gcnt++;
                n_checks++;
                if (req_ready !== '0 || rsp_valid !== 1'b0) $display("FAIL gap_quiet: req_ready %b rsp_valid %b want 0 0", req_ready, rsp_valid);
                else n_pass++;
            end else begin
                ok = 1'b1;
            end
        end
        n_checks++; if (gcnt != 3) $display("FAIL gap_len: %0d gap cycles want 3", gcnt); else n_pass++;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL gap_idle: req_ready %b want 01", req_ready); else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp(ok);
        n_checks++; if (!ok) $display("FAIL bp_drain: no response within bound"); else n_pass++;
    endtask

    task automatic test_seed();
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        seed_load = 1'b1;
        seed      = 32'h0;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        seed      = 32'h1234_5678;
        set_ops(1, 4'h5, 4'hA, 4'hF, 4'h0);
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        @(negedge clk);
        n_checks++; if (dut.u_lfsr.state_q !== 32'h1) $display("FAIL seed_zero: lfsr %h want 00000001", dut.u_lfsr.state_q); else n_pass++;
        n_checks++; if (req_ready !== 2'b10) $display("FAIL seed_ready: req_ready %b want 10", req_ready); else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (dut.rnd !== 12'h003) $display("FAIL seed_rnd: r bits %h want 003", dut.rnd); else n_pass++;
        wait_rsp(ok);
        n_checks++; if (!ok) $display("FAIL seed_drain: no response within bound"); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        set_ops(0, 4'hC, 4'h4, 4'h9, 4'h2);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        wait_accept(0, ok);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_resp: rsp_valid %b want 1 before reset", rsp_valid); else n_pass++;
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_y0 !== '0 || rsp_y1 !== '0 || rsp_id !== '0 || busy !== 1'b0)
            $display("FAIL mid_clear: valid %b y %h/%h id %0d busy %b want all 0", rsp_valid, rsp_y0, rsp_y1, rsp_id, busy);
        else n_pass++;
        n_checks++; if (dut.u_lfsr.state_q !== SEED) $display("FAIL mid_lfsr: got %h want %h", dut.u_lfsr.state_q, SEED); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        set_ops(1, 4'h1, 4'h1, 4'h1, 4'h1);
        set_ops(0, 4'hF, 4'h0, 4'h0, 4'h6);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) $display("FAIL mid_rrptr: req_ready %b want 01", req_ready); else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || (rsp_y0 ^ rsp_y1) !== 4'h9)
            $display("FAIL mid_after: valid %b id %0d unmasked %h want 1 0 9", rsp_valid, rsp_id, rsp_y0 ^ rsp_y1);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit got, done;
        for (int op = 0; op < 1000; op++) begin
            for (int i = 0; i < NUM_REQ; i++)
                set_ops(i, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            gap_cycles = 4'($urandom_range(0, 2));
            req_valid  = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            rsp_ready  = 1'($urandom_range(0, 1));
            got  = 1'b0;
            done = 1'b0;
            for (int n = 0; n < 60 && !done; n++) begin
                @(negedge clk);
                if (|(req_valid & req_ready)) got = 1'b1;
                if (rsp_valid && rsp_ready) done = 1'b1;
                @(posedge clk);
                #1;
                if (got) req_valid = '0;
                rsp_ready = 1'($urandom_range(0, 1));
                seed_load = ($urandom_range(0, 15) == 0);
                seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            end
            seed_load = 1'b0;
            n_checks++; if (!done) $display("FAIL rand_timeout: op %0d accepted %b without response", op, got); else n_pass++;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid  = '0;
        req_a0     = '0;
        req_a1     = '0;
        req_b0     = '0;
        req_b1     = '0;
        rsp_ready  = 1'b0;
        gap_cycles = 4'd0;
        seed_load  = 1'b0;
        seed       = 32'h0;
        have_prev  = 1'b0;
        eval_pend  = 1'b0;
        m_rr       = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure_gap();
        test_seed();
        test_reset_mid();
        test_random();
        n_checks++; if (q.size() != 0) $display("FAIL sb_leftover: %0d results never returned", q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
